// File: rtl/joypad_port_array.sv
// joypad_port_array: strobe-latched serial joypad ports with per-channel press-synchronised autofire
module joypad_port_array #(
  parameter int CHANNELS = 2,
  parameter int BITS = 8,
  parameter int FREQ = 25_000_000,
  parameter int AUTOFIRE_HZ = 15,
  parameter logic FILL = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNELS*BITS-1:0] btn_in,
  input  logic [CHANNELS*BITS-1:0] turbo_mask,
  input  logic                     strobe,
  input  logic [CHANNELS-1:0]      joy_clk,
  output logic [CHANNELS-1:0]      joy_data,
  output logic [CHANNELS-1:0]      reads_done
);
  localparam int TICKS_RAW = FREQ / (2 * AUTOFIRE_HZ);
  localparam int TICKS = TICKS_RAW < 1 ? 1 : TICKS_RAW;
  localparam int CW = $clog2(BITS + 1);
  localparam int AW = TICKS > 1 ? $clog2(TICKS) : 1;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [BITS-1:0] sr, b, m, eff;
    logic [CW-1:0] cnt;
    logic [AW-1:0] ac;
    logic ph, lj, rd, any_turbo, fall;
    always_comb begin
      b = btn_in[i*BITS +: BITS];
      m = turbo_mask[i*BITS +: BITS];
      eff = b & (~m | {BITS{ph}});
      any_turbo = |(b & m);
      fall = lj & ~joy_clk[i];
    end
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sr <= '0;
        cnt <= '0;
        rd <= 1'b0;
        lj <= 1'b0;
        ac <= '0;
        ph <= 1'b1;
      end else begin
        lj <= joy_clk[i];
        if (!any_turbo) begin
          ac <= '0;
          ph <= 1'b1;
        end else if (ac == AW'(TICKS - 1)) begin
          ac <= '0;
          ph <= ~ph;
        end else begin
          ac <= ac + 1'b1;
        end
        // strobe reload takes priority over a coincident falling edge
        if (strobe) begin
          sr <= eff;
          cnt <= '0;
          rd <= 1'b0;
        end else if (fall) begin
          sr <= BITS'({FILL, sr} >> 1);
          cnt <= cnt == CW'(BITS) ? cnt : cnt + 1'b1;
          rd <= ({1'b0, cnt} + 1'b1) >= (CW+1)'(BITS);
        end
      end
    end
    assign joy_data[i] = sr[0];
    assign reads_done[i] = rd;
  end
endmodule

// File: tb/tb_joypad_port_array.sv
// tb_joypad_port_array: directed and random checks against a read-count reference model
module tb_joypad_port_array;
  localparam int CH = 2, B = 8, T = 5;
  logic clk = 0, reset = 1, strobe = 0;
  logic [CH*B-1:0] btn_in = '0, turbo_mask = '0;
  logic [CH-1:0] joy_clk = '0, joy_data, reads_done;
  int total = 0, bad = 0;
  int held[CH], n[CH];
  logic [B-1:0] val[CH];
  logic prev[CH];
  logic [15:0] pat;

  always #5 clk = ~clk;

  joypad_port_array #(.CHANNELS(CH), .BITS(B), .FREQ(1000), .AUTOFIRE_HZ(100), .FILL(1'b1)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .turbo_mask(turbo_mask),
    .strobe(strobe), .joy_clk(joy_clk), .joy_data(joy_data), .reads_done(reads_done)
  );

  task automatic chk(input string tag, input logic [CH-1:0] o, input logic [CH-1:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%b want=%b", tag, o, e);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      held[c] = 0;
      n[c] = 0;
      val[c] = '0;
      prev[c] = 1'b0;
    end
  endtask

  task automatic tick();
    logic [CH-1:0] ed, er;
    @(posedge clk);
    for (int c = 0; c < CH; c++) begin
      logic [B-1:0] bb, mm, eff;
      logic ph, fl;
      bb = btn_in[c*B +: B];
      mm = turbo_mask[c*B +: B];
      ph = ((held[c] / T) % 2) == 0;
      eff = bb & (~mm | {B{ph}});
      held[c] = |(bb & mm) ? held[c] + 1 : 0;
      fl = prev[c] & ~joy_clk[c];
      prev[c] = joy_clk[c];
      if (strobe) begin
        val[c] = eff;
        n[c] = 0;
      end else if (fl && n[c] < 1000) n[c]++;
    end
    #1;
    for (int c = 0; c < CH; c++) begin
      ed[c] = n[c] < B ? val[c][n[c]] : 1'b1;
      er[c] = n[c] >= B;
    end
    chk("model_data", joy_data, ed);
    chk("model_done", reads_done, er);
  endtask

  task automatic fall(input int c);
    joy_clk[c] = 1'b1;
    tick();
    joy_clk[c] = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    chk("reset_data", joy_data, '0);
    chk("reset_done", reads_done, '0);
    @(negedge clk) reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    chk("por_data", joy_data, '0);
    chk("por_done", reads_done, '0);
    @(negedge clk) reset = 1'b0;
    tick();
    btn_in[7:0] = 8'h85;
    pat = 16'hFF85;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    chk("seq_first", joy_data[0], 1'b1);
    for (int j = 1; j <= 11; j++) begin
      fall(0);
      chk("seq_bit", joy_data[0], pat[j]);
      chk("seq_done", reads_done[0], j >= 8);
    end
    strobe = 1'b1;
    btn_in[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      joy_clk[0] = ~joy_clk[0];
      if (k == 10) btn_in[0] = 1'b1;
      tick();
      chk("hold_data", joy_data[0], k >= 10);
      chk("hold_done", reads_done[0], 1'b0);
    end
    btn_in = '0;
    joy_clk = '0;
    tick();
    turbo_mask[8] = 1'b1;
    btn_in[8] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("turbo", joy_data[1], ((k / 5) % 2) == 0);
    end
    btn_in[8] = 1'b0;
    tick();
    btn_in[8] = 1'b1;
    tick();
    chk("turbo_rephase", joy_data[1], 1'b1);
    strobe = 1'b0;
    btn_in = '0;
    turbo_mask = '0;
    btn_in[7:0] = 8'h3C;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    joy_clk[0] = 1'b1;
    tick();
    btn_in[7:0] = 8'h01;
    joy_clk[0] = 1'b0;
    strobe = 1'b1;
    tick();
    chk("collide", joy_data[0], 1'b1);
    strobe = 1'b0;
    fall(0);
    chk("collide_next", joy_data[0], 1'b0);
    btn_in = {8'h5B, 8'hA6};
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    fall(0);
    fall(0);
    fall(0);
    chk("inter_ch1_idle", joy_data[1], 1'b1);
    fall(1);
    chk("inter", joy_data, 2'b10);
    btn_in[7:0] = 8'hF1;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    for (int j = 0; j < 4; j++) fall(0);
    chk("pre_reset", joy_data[0], 1'b1);
    do_reset();
    tick();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    chk("restart_b0", joy_data[0], 1'b1);
    fall(0);
    chk("restart_b1", joy_data[0], 1'b0);
    for (int k = 0; k < 3000; k++) begin
      strobe = $urandom_range(0, 19) == 0;
      joy_clk = CH'($urandom);
      if ($urandom_range(0, 9) == 0) btn_in = (CH*B)'($urandom);
      if ($urandom_range(0, 49) == 0) turbo_mask = (CH*B)'($urandom);
      if (k == 1500) do_reset();
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
